// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and parameter range checks for the hazard control unit
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int CNT_BITS = 4;

  // Both the memory latency and flush depth must fit the 4-bit down-counter.
  function automatic bit len_ok(input int len);
    return (len >= 1) && (len <= (1 << CNT_BITS) - 1);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - combinational load-use match of p1 sources against the p3 destination
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 3,
  parameter int NUM_SRC = 2
) (
  input  logic                      mem_read,
  input  logic [REG_AW-1:0]         rd,
  input  logic [NUM_SRC*REG_AW-1:0] src,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic                      hit
);

  logic [NUM_SRC-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      match[i] = src_valid[i] && (src[i*REG_AW +: REG_AW] == rd);
    end
    hit = mem_read && (|match);
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - load-use stall and branch flush sequencer with saturating statistics
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 3,
  parameter int NUM_SRC     = 2,
  parameter int MEM_LAT     = 1,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      op_mem_read23,
  input  logic [REG_AW-1:0]         rd23,
  input  logic [NUM_SRC*REG_AW-1:0] src12,
  input  logic [NUM_SRC-1:0]        src_valid12,
  input  logic                      op_branch23,
  output logic                      op_stall_data,
  output logic                      op_stall_ctrl,
  output logic                      busy,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  if (!len_ok(MEM_LAT)) begin : g_bad_mem_lat
    $error("hazard_ctrl_unit: MEM_LAT must be in 1..15");
  end
  if (!len_ok(FLUSH_DEPTH)) begin : g_bad_flush_depth
    $error("hazard_ctrl_unit: FLUSH_DEPTH must be in 1..15");
  end

  // The detection cycle itself (in IDLE) is the first stalled/flushed cycle,
  // so the counter covers only the remaining length-1 cycles.
  localparam logic [CNT_BITS-1:0] LAT_INIT   = CNT_BITS'(MEM_LAT - 1);
  localparam logic [CNT_BITS-1:0] FLUSH_INIT = CNT_BITS'(FLUSH_DEPTH - 1);

  state_t              state;
  logic [CNT_BITS-1:0] cnt;
  logic                busy_q;
  logic [CNT_W-1:0]    stall_q;
  logic [CNT_W-1:0]    flush_q;
  logic                hit;
  logic                data_raw;
  logic                ctrl_raw;

  hazard_src_match #(
    .REG_AW  (REG_AW),
    .NUM_SRC (NUM_SRC)
  ) u_src_match (
    .mem_read  (op_mem_read23),
    .rd        (rd23),
    .src       (src12),
    .src_valid (src_valid12),
    .hit       (hit)
  );

  // A taken branch wins in every state, so it also masks an ongoing stall.
  always_comb begin
    ctrl_raw = op_branch23 || (state == FLUSH);
    data_raw = !op_branch23 && (((state == IDLE) && hit) || (state == STALL));
  end

  assign op_stall_data = data_raw && !reset;
  assign op_stall_ctrl = ctrl_raw && !reset;
  assign busy          = busy_q && !reset;
  assign stall_cnt     = stall_q;
  assign flush_cnt     = flush_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (data_raw && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (ctrl_raw && op_branch23 && (flush_q != '1)) begin
        flush_q <= flush_q + 1'b1;
      end

      if (op_branch23) begin
        cnt <= FLUSH_INIT;
        if (FLUSH_DEPTH > 1) begin
          state  <= FLUSH;
          busy_q <= 1'b1;
        end else begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (hit && (MEM_LAT > 1)) begin
              state  <= STALL;
              cnt    <= LAT_INIT;
              busy_q <= 1'b1;
            end
          end
          STALL, FLUSH: begin
            if (cnt < CNT_BITS'(2)) begin
              state  <= IDLE;
              cnt    <= '0;
              busy_q <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - scoreboard bench for hazard_ctrl_unit at two latency/width configurations
module tb_hazard_ctrl_unit;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_a, reset_b;
  logic       op_mem_read23, op_branch23;
  logic [2:0] rd23;
  logic [5:0] src12;
  logic [1:0] src_valid12;

  logic        a_data, a_ctrl, a_busy;
  logic [15:0] a_scnt, a_fcnt;
  logic        b_data, b_ctrl, b_busy;
  logic [3:0]  b_scnt, b_fcnt;

  hazard_ctrl_unit #(
    .REG_AW(3), .NUM_SRC(2), .MEM_LAT(1), .FLUSH_DEPTH(2), .CNT_W(16)
  ) dut_a (
    .clock         (clock),
    .reset         (reset_a),
    .op_mem_read23 (op_mem_read23),
    .rd23          (rd23),
    .src12         (src12),
    .src_valid12   (src_valid12),
    .op_branch23   (op_branch23),
    .op_stall_data (a_data),
    .op_stall_ctrl (a_ctrl),
    .busy          (a_busy),
    .stall_cnt     (a_scnt),
    .flush_cnt     (a_fcnt)
  );

  hazard_ctrl_unit #(
    .REG_AW(3), .NUM_SRC(2), .MEM_LAT(3), .FLUSH_DEPTH(2), .CNT_W(4)
  ) dut_b (
    .clock         (clock),
    .reset         (reset_b),
    .op_mem_read23 (op_mem_read23),
    .rd23          (rd23),
    .src12         (src12),
    .src_valid12   (src_valid12),
    .op_branch23   (op_branch23),
    .op_stall_data (b_data),
    .op_stall_ctrl (b_ctrl),
    .busy          (b_busy),
    .stall_cnt     (b_scnt),
    .flush_cnt     (b_fcnt)
  );

  typedef struct {
    int          sel;
    int          id;
    logic        data;
    logic        ctrl;
    logic        busy;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   vid   = 0;

  task automatic check(input string nm, input int id, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %0d expected %0d", nm, id, act, exp);
    end
  endtask

  // Monitor: compares the selected DUT at mid-cycle against the queued expectation.
  exp_t        m_e;
  logic [15:0] m_d, m_c, m_b, m_s, m_f;
  always @(negedge clock) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      n_vec++;
      if (m_e.sel == 0) begin
        m_d = {15'b0, a_data}; m_c = {15'b0, a_ctrl}; m_b = {15'b0, a_busy};
        m_s = a_scnt;          m_f = a_fcnt;
      end else begin
        m_d = {15'b0, b_data}; m_c = {15'b0, b_ctrl}; m_b = {15'b0, b_busy};
        m_s = {12'b0, b_scnt}; m_f = {12'b0, b_fcnt};
      end
      check("stall_data", m_e.id, m_d, {15'b0, m_e.data});
      check("stall_ctrl", m_e.id, m_c, {15'b0, m_e.ctrl});
      check("busy",       m_e.id, m_b, {15'b0, m_e.busy});
      check("stall_cnt",  m_e.id, m_s, m_e.scnt);
      check("flush_cnt",  m_e.id, m_f, m_e.fcnt);
    end
  end

  // Drive one cycle of stimulus to the selected DUT (the other is held in reset)
  // and queue its hand-computed response for that cycle.
  task automatic apply(input int sel, input logic rst, input logic mr, input logic [2:0] rd,
                       input logic [2:0] s1, input logic [2:0] s0, input logic [1:0] sv,
                       input logic br, input logic ed, input logic ec, input logic eb,
                       input int es, input int ef);
    exp_t e;
    @(posedge clock); #1;
    if (sel == 0) begin reset_a = rst; reset_b = 1'b1; end
    else          begin reset_a = 1'b1; reset_b = rst; end
    op_mem_read23 = mr; rd23 = rd; src12 = {s1, s0}; src_valid12 = sv; op_branch23 = br;
    e.sel = sel; e.id = vid; e.data = ed; e.ctrl = ec; e.busy = eb;
    e.scnt = 16'(es); e.fcnt = 16'(ef);
    vid++;
    q.push_back(e);
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    op_mem_read23 = 1'b0; rd23 = '0; src12 = '0; src_valid12 = '0; op_branch23 = 1'b0;
    repeat (2) @(posedge clock);

    // MEM_LAT=1, FLUSH_DEPTH=2, CNT_W=16
    apply(0, 1, 1, 3, 5, 3, 2'b11, 0,  0, 0, 0, 0, 0);
    apply(0, 0, 1, 4, 4, 2, 2'b01, 0,  0, 0, 0, 0, 0);
    apply(0, 0, 1, 3, 5, 3, 2'b11, 0,  1, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 2'b00, 0,  0, 0, 0, 1, 0);
    apply(0, 0, 1, 3, 5, 3, 2'b11, 1,  0, 1, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 2'b00, 0,  0, 1, 1, 1, 1);
    apply(0, 0, 0, 0, 0, 0, 2'b00, 0,  0, 0, 0, 1, 1);
    apply(0, 0, 1, 0, 7, 0, 2'b11, 0,  1, 0, 0, 1, 1);
    apply(0, 0, 1, 6, 6, 6, 2'b00, 0,  0, 0, 0, 2, 1);
    apply(0, 0, 0, 0, 0, 0, 2'b00, 1,  0, 1, 0, 2, 1);
    apply(0, 0, 0, 0, 0, 0, 2'b00, 1,  0, 1, 1, 2, 2);
    apply(0, 0, 0, 0, 0, 0, 2'b00, 0,  0, 1, 1, 2, 3);
    apply(0, 0, 0, 0, 0, 0, 2'b00, 0,  0, 0, 0, 2, 3);
    apply(0, 0, 0, 0, 0, 0, 2'b00, 1,  0, 1, 0, 2, 3);
    apply(0, 1, 0, 0, 0, 0, 2'b00, 0,  0, 0, 0, 2, 4);
    apply(0, 0, 0, 0, 0, 0, 2'b00, 0,  0, 0, 0, 0, 0);

    // MEM_LAT=3, FLUSH_DEPTH=2, CNT_W=4
    apply(1, 0, 1, 3, 5, 3, 2'b11, 0,  1, 0, 0, 0, 0);
    apply(1, 0, 1, 3, 5, 3, 2'b11, 0,  1, 0, 1, 1, 0);
    apply(1, 0, 0, 0, 0, 0, 2'b00, 0,  1, 0, 1, 2, 0);
    apply(1, 0, 0, 0, 0, 0, 2'b00, 0,  0, 0, 0, 3, 0);
    apply(1, 1, 0, 0, 0, 0, 2'b00, 0,  0, 0, 0, 3, 0);
    apply(1, 0, 1, 3, 5, 3, 2'b11, 0,  1, 0, 0, 0, 0);
    apply(1, 0, 1, 3, 5, 3, 2'b11, 1,  0, 1, 1, 1, 0);
    apply(1, 0, 0, 0, 0, 0, 2'b00, 0,  0, 1, 1, 1, 1);
    apply(1, 0, 0, 0, 0, 0, 2'b00, 0,  0, 0, 0, 1, 1);
    apply(1, 1, 0, 0, 0, 0, 2'b00, 0,  0, 0, 0, 1, 1);
    for (int k = 0; k < 21; k++) begin
      apply(1, 0, 1, 3, 5, 3, 2'b11, 0,  1, 0, (k % 3) != 0, (k > 15) ? 15 : k, 0);
    end
    apply(1, 0, 0, 0, 0, 0, 2'b00, 0,  0, 0, 0, 15, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
